// File: rtl/key_clock_pkg.sv
// Shared encodings and limits for the settable 24-hour key clock.
package key_clock_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      SET_H = 2'd1,
      SET_M = 2'd2,
      SET_S = 2'd3
   } state_t;

   localparam int KEY_MODE    = 0;
   localparam int KEY_UP      = 1;
   localparam int KEY_DOWN    = 2;
   localparam int KEY_CONFIRM = 3;

   localparam int HOUR_MAX    = 23;
   localparam int MIN_SEC_MAX = 59;

   // MODE walks the set fields in a ring: hour, minute, second, back to hour.
   function automatic state_t nextSetState(input state_t s);
      case (s)
         SET_H:   return SET_M;
         SET_M:   return SET_S;
         default: return SET_H;
      endcase
   endfunction

endpackage

// File: rtl/key_clock_ctrl_if.sv
// Key pulses in, time fields and display status out.
interface key_clock_ctrl_if;
   logic [3:0] key_pulse;
   logic [4:0] hour;
   logic [5:0] minute;
   logic [5:0] second;
   logic [1:0] mode;
   logic       blink_on;
   logic       sec_tick;

   modport master (
      output key_pulse,
      input  hour, minute, second, mode, blink_on, sec_tick
   );

   modport slave (
      input  key_pulse,
      output hour, minute, second, mode, blink_on, sec_tick
   );
endinterface

// File: rtl/mod_counter.sv
// Wrapping 0..MAX up/down counter; carry flags an increment out of MAX.
module mod_counter #(
   parameter int MAX   = 59,
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             dec,
   output logic [WIDTH-1:0] value,
   output logic             carry
);

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

   logic [WIDTH-1:0] value_q, value_d;

   // Out-of-range values cannot be reached, but fold them back to 0 if they ever appear.
   always_comb begin
      value_d = value_q;
      if (value_q > MAX_V)
         value_d = '0;
      else if (inc)
         value_d = (value_q == MAX_V) ? '0 : value_q + WIDTH'(1);
      else if (dec)
         value_d = (value_q == '0) ? MAX_V : value_q - WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (rst)
         value_q <= '0;
      else
         value_q <= value_d;
   end

   assign value = value_q;
   assign carry = inc && (value_q == MAX_V);

endmodule

// File: rtl/key_clock_ctrl.sv
// 24-hour clock with a run mode and a field-by-field set mode driven by debounced key pulses.
module key_clock_ctrl
   import key_clock_pkg::*;
#(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BLINK_CYC = 25_000_000
) (
   input  logic clk,
   input  logic rst,
   key_clock_ctrl_if.slave bus
);

   localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
   localparam int BW = $clog2(BLINK_CYC);
   localparam logic [PW-1:0] PRE_MAX   = PW'(CLK_FREQ - 1);
   localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_CYC - 1);

   state_t        state_q;
   logic [PW-1:0] pre_q;
   logic [BW-1:0] blink_q;
   logic          blinkOn_q;
   logic          tick_q;

   logic keyMode, keyUp, keyDown, keyConfirm;
   logic runTick;
   logic secInc, secDec, minInc, minDec, hourInc, hourDec;
   logic secCarry, minCarry, hourCarry;
   logic [5:0] secVal, minVal;
   logic [4:0] hourVal;

   // Lowest-numbered key wins; everything else in the same pulse is dropped.
   assign keyMode    = bus.key_pulse[KEY_MODE];
   assign keyUp      = bus.key_pulse[KEY_UP] && !bus.key_pulse[KEY_MODE];
   assign keyDown    = bus.key_pulse[KEY_DOWN] && !bus.key_pulse[KEY_UP] && !bus.key_pulse[KEY_MODE];
   assign keyConfirm = bus.key_pulse[KEY_CONFIRM] && !bus.key_pulse[KEY_DOWN]
                       && !bus.key_pulse[KEY_UP] && !bus.key_pulse[KEY_MODE];

   assign runTick = (state_q == RUN) && (pre_q == PRE_MAX);

   // Carries only ripple while running; set-mode edits stay within one field.
   assign secInc  = runTick || ((state_q == SET_S) && keyUp);
   assign secDec  = (state_q == SET_S) && keyDown;
   assign minInc  = ((state_q == RUN) && secCarry) || ((state_q == SET_M) && keyUp);
   assign minDec  = (state_q == SET_M) && keyDown;
   assign hourInc = ((state_q == RUN) && minCarry) || ((state_q == SET_H) && keyUp);
   assign hourDec = (state_q == SET_H) && keyDown;

   mod_counter #(.MAX(MIN_SEC_MAX), .WIDTH(6)) u_second (
      .clk(clk), .rst(rst), .inc(secInc), .dec(secDec), .value(secVal), .carry(secCarry)
   );

   mod_counter #(.MAX(MIN_SEC_MAX), .WIDTH(6)) u_minute (
      .clk(clk), .rst(rst), .inc(minInc), .dec(minDec), .value(minVal), .carry(minCarry)
   );

   mod_counter #(.MAX(HOUR_MAX), .WIDTH(5)) u_hour (
      .clk(clk), .rst(rst), .inc(hourInc), .dec(hourDec), .value(hourVal), .carry(hourCarry)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= RUN;
         pre_q     <= '0;
         blink_q   <= '0;
         blinkOn_q <= 1'b1;
         tick_q    <= 1'b0;
      end else begin
         tick_q <= runTick;
         case (state_q)
            RUN: begin
               pre_q     <= runTick ? '0 : pre_q + PW'(1);
               blink_q   <= '0;
               blinkOn_q <= 1'b1;
               if (keyMode) begin
                  state_q <= SET_H;
                  pre_q   <= '0;
               end
            end
            default: begin
               pre_q <= '0;
               // Any edit restarts the blink phase so the field is visible right after a key.
               if (keyMode || keyUp || keyDown) begin
                  blink_q   <= '0;
                  blinkOn_q <= 1'b1;
                  if (keyMode)
                     state_q <= nextSetState(state_q);
               end else if (keyConfirm) begin
                  state_q   <= RUN;
                  blink_q   <= '0;
                  blinkOn_q <= 1'b1;
               end else if (blink_q == BLINK_MAX) begin
                  blink_q   <= '0;
                  blinkOn_q <= !blinkOn_q;
               end else begin
                  blink_q <= blink_q + BW'(1);
               end
            end
         endcase
      end
   end

   assign bus.hour     = hourVal;
   assign bus.minute   = minVal;
   assign bus.second   = secVal;
   assign bus.mode     = state_q;
   assign bus.blink_on = blinkOn_q;
   assign bus.sec_tick = tick_q;

   // The hour wrap has no consumer above this block.
   logic unusedHourCarry;
   assign unusedHourCarry = hourCarry;

endmodule
